// File: rtl/vpc_mt.sv
// ============================================================================
// Module  : vpc_mt
// Brief   : Multi-thread virtual PC with round-robin thread select, per-thread
//           redirect/exception load and global stall. Optional misaligned-redirect
//           check enabled by defining VPC_ALIGN_CHK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vpc_mt #(
    parameter int               WIDTH     = 32,
    parameter int               NTHR      = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h8000_0000,
    parameter logic [WIDTH-1:0] EXC_VEC   = 32'h8000_0180,
    parameter int               INC       = 4,
    localparam int              TW        = (NTHR > 1) ? $clog2(NTHR) : 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             stall,
    input  logic [NTHR-1:0]  thr_en,
    input  logic             redirect,
    input  logic [TW-1:0]    redirect_tid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             exc,
    input  logic [TW-1:0]    exc_tid,
    output logic             valid,
    output logic [WIDTH-1:0] pc,
    output logic [TW-1:0]    tid,
    output logic             adel
);

    logic [WIDTH-1:0] r_pc [NTHR];
    logic [TW-1:0]    r_last;

    logic [TW-1:0]    w_sel;
    logic             w_found;
    int               w_idx;
    logic             w_valid;
    logic [WIDTH-1:0] w_redir_val;

    // Round-robin scan starting just after the last served thread
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NTHR; k++) begin
            w_idx = (int'(r_last) + k) % NTHR;
            if (!w_found && thr_en[w_idx]) begin
                w_found = 1'b1;
                w_sel   = TW'(w_idx);
            end
        end
    end

    assign w_valid = (|thr_en) & ~stall;
    assign valid   = w_valid;
    assign pc      = r_pc[w_sel];
    assign tid     = w_sel;

`ifdef VPC_ALIGN_CHK_EN
    logic w_rd_in_range;
    logic w_misal;

    always_comb begin
        w_rd_in_range = 1'b0;
        for (int i = 0; i < NTHR; i++) begin
            if (redirect_tid == TW'(i)) begin
                w_rd_in_range = 1'b1;
            end
        end
    end

    assign w_misal     = (redirect_pc[1:0] != 2'b00);
    assign w_redir_val = w_misal ? EXC_VEC : redirect_pc;
    assign adel        = redirect & w_misal & w_rd_in_range;
`else
    assign w_redir_val = redirect_pc;
    assign adel        = 1'b0;
`endif

    // Priority per thread: exception > redirect > sequential increment.
    // Out-of-range tids never match any thread index and are dropped.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NTHR; i++) begin
                r_pc[i] <= RESET_VEC;
            end
            r_last <= TW'(NTHR - 1);
        end else begin
            for (int i = 0; i < NTHR; i++) begin
                if (exc && (exc_tid == TW'(i))) begin
                    r_pc[i] <= EXC_VEC;
                end else if (redirect && (redirect_tid == TW'(i))) begin
                    r_pc[i] <= w_redir_val;
                end else if (w_valid && (w_sel == TW'(i))) begin
                    r_pc[i] <= r_pc[i] + WIDTH'(INC);
                end
            end
            if (w_valid) begin
                r_last <= w_sel;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vpc_mt.sv
// Scoreboard bench for vpc_mt: stimulus process runs a reference model and queues
// expected outputs; a monitor process pops and compares every cycle.
`default_nettype none

module tb_vpc_mt;

    localparam int               W   = 32;
    localparam int               N   = 4;
    localparam int               TW  = 2;
    localparam logic [W-1:0]     RV  = 32'h8000_0000;
    localparam logic [W-1:0]     EV  = 32'h8000_0180;
`ifdef VPC_ALIGN_CHK_EN
    localparam bit               ALIGN = 1'b1;
`else
    localparam bit               ALIGN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          stall = 1'b0;
    logic [N-1:0]  thr_en = '0;
    logic          redirect = 1'b0;
    logic [TW-1:0] redirect_tid = '0;
    logic [W-1:0]  redirect_pc = '0;
    logic          exc = 1'b0;
    logic [TW-1:0] exc_tid = '0;
    logic          valid;
    logic [W-1:0]  pc;
    logic [TW-1:0] tid;
    logic          adel;

    always #5 clk = ~clk;

    vpc_mt dut (
        .clk          (clk),
        .clr          (clr),
        .stall        (stall),
        .thr_en       (thr_en),
        .redirect     (redirect),
        .redirect_tid (redirect_tid),
        .redirect_pc  (redirect_pc),
        .exc          (exc),
        .exc_tid      (exc_tid),
        .valid        (valid),
        .pc           (pc),
        .tid          (tid),
        .adel         (adel)
    );

    typedef struct packed {
        logic          chk;
        logic          v;
        logic [W-1:0]  pc;
        logic [TW-1:0] tid;
        logic          adel;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] m_pc [N];
    int           m_last = N - 1;
    int           n_cmp = 0;
    int           n_bad = 0;
    bit           done = 1'b0;

    task automatic cmp(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One stimulus cycle: drive inputs, predict outputs, then advance the model
    task automatic cyc(input logic c, input logic s, input logic [N-1:0] en,
                       input logic rd, input int rt, input logic [W-1:0] rp,
                       input logic ex, input int et);
        exp_t e;
        int   sel;
        logic v;
        logic mis;
        @(negedge clk);
        clr = c; stall = s; thr_en = en;
        redirect = rd; redirect_tid = TW'(rt); redirect_pc = rp;
        exc = ex; exc_tid = TW'(et);
        sel = 0;
        for (int k = 1; k <= N; k++) begin
            if (en[(m_last + k) % N]) begin
                sel = (m_last + k) % N;
                break;
            end
        end
        v   = (en != '0) && !s;
        mis = (rp[1:0] != 2'b00);
        e.chk  = !c;
        e.v    = v;
        e.pc   = m_pc[sel];
        e.tid  = TW'(sel);
        e.adel = ALIGN && rd && mis;
        q.push_back(e);
        if (c) begin
            for (int i = 0; i < N; i++) m_pc[i] = RV;
            m_last = N - 1;
        end else begin
            if (v) begin
                m_pc[sel] = m_pc[sel] + 32'd4;
                m_last    = sel;
            end
            if (rd) m_pc[rt] = (ALIGN && mis) ? EV : rp;
            if (ex) m_pc[et] = EV;
        end
    endtask

    task automatic run(input int n, input logic [N-1:0] en);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, en, 1'b0, 0, '0, 1'b0, 0);
    endtask

    task automatic rst();
        cyc(1'b1, 1'b0, 4'b1111, 1'b0, 0, '0, 1'b0, 0);
    endtask

    // Monitor: consumes one expectation per cycle, after inputs have settled
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    cmp("valid", W'(valid), W'(e.v));
                    cmp("pc",    pc,        e.pc);
                    cmp("tid",   W'(tid),   W'(e.tid));
                    cmp("adel",  W'(adel),  W'(e.adel));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) m_pc[i] = 'x;
        rst(); rst();
        run(5, 4'b1111);
        // Alternating subset, then no threads enabled
        rst(); run(4, 4'b0101); run(2, 4'b0000); run(3, 4'b0101);
        // Redirect and exception onto the thread currently being fetched
        rst(); run(1, 4'b1111);
        cyc(1'b0, 1'b0, 4'b1111, 1'b1, 1, 32'h0040_0000, 1'b0, 0);
        run(4, 4'b1111);
        rst(); run(1, 4'b1111);
        cyc(1'b0, 1'b0, 4'b1111, 1'b1, 1, 32'h0040_0000, 1'b1, 1);
        run(4, 4'b1111);
        // Stall with a redirect to thread 2 taken during the stall
        rst(); run(1, 4'b1111);
        cyc(1'b0, 1'b1, 4'b1111, 1'b0, 0, '0, 1'b0, 0);
        cyc(1'b0, 1'b1, 4'b1111, 1'b1, 2, 32'h0012_3400, 1'b0, 0);
        cyc(1'b0, 1'b1, 4'b1111, 1'b0, 0, '0, 1'b0, 0);
        run(4, 4'b1111);
        // Wrap at the top of the address space
        rst(); cyc(1'b0, 1'b1, 4'b1111, 1'b1, 0, 32'hFFFF_FFFC, 1'b0, 0);
        run(5, 4'b1111);
        // Misaligned redirect
        rst(); cyc(1'b0, 1'b0, 4'b1111, 1'b1, 3, 32'h0040_0002, 1'b0, 0);
        run(4, 4'b1111);
        // Single enabled thread
        run(3, 4'b0100);
        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [W-1:0] rp;
            rp = $urandom();
            if ($urandom_range(0, 5) == 0) rp = 32'hFFFF_FFF8 | (rp & 32'h7);
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
                N'($urandom()), ($urandom_range(0, 3) == 0), $urandom_range(0, N - 1), rp,
                ($urandom_range(0, 6) == 0), $urandom_range(0, N - 1));
        end
        @(negedge clk);
        #4;
        done = 1'b1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
